display_window_scheduler: RTL and testbench

//  Sequences partial-window updates for the 8-bit 8080 ILI9486 panel path. Per accepted window request it

---
 rtl/display_window_scheduler_pkg.sv | 74 +++++++
 rtl/display_byte_out_reg.sv | 48 ++++
 rtl/display_window_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_display_window_scheduler.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_window_scheduler_pkg.sv
// Shared definitions for the ILI9486 partial-window scheduler: command bytes,
// window field layout, counter widths, FSM encoding and the command-byte table.
package display_window_scheduler_pkg;

  localparam int WIN_COORD_WIDTH = 9;
  localparam int PIX_CNT_WIDTH   = 2 * WIN_COORD_WIDTH;
  localparam int WIN_DATA_WIDTH  = 4 * WIN_COORD_WIDTH;

  localparam logic [7:0] ILI_CASET = 8'h2A;
  localparam logic [7:0] ILI_PASET = 8'h2B;
  localparam logic [7:0] ILI_RAMWR = 8'h2C;

  // Index of the final command byte (RAMWR) in the 11-byte preamble.
  localparam logic [3:0] CMD_LAST_IDX = 4'd10;

  typedef logic [WIN_COORD_WIDTH-1:0] coord_t;
  typedef logic [WIN_COORD_WIDTH:0]   coord_ext_t;
  typedef logic [PIX_CNT_WIDTH-1:0]   pix_cnt_t;

  // Field order fixes the bus offsets: x0 [35:27], y0 [26:18], x1 [17:9], y1 [8:0].
  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
  } win_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CMD,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       user;
  } out_byte_t;

  // Command preamble byte for a given index; coordinates are sent as 16-bit
  // big-endian parameters, DC low only on the three command opcodes.
  function automatic out_byte_t cmd_byte(input logic [3:0] idx, input win_t w,
                                         input logic [7:0] caset, input logic [7:0] paset,
                                         input logic [7:0] ramwr);
    out_byte_t  b;
    logic [15:0] x0w;
    logic [15:0] y0w;
    logic [15:0] x1w;
    logic [15:0] y1w;
    x0w    = 16'(w.x0);
    y0w    = 16'(w.y0);
    x1w    = 16'(w.x1);
    y1w    = 16'(w.y1);
    b.user = 1'b1;
    b.data = 8'h00;
    case (idx)
      4'd0:    begin b.data = caset; b.user = 1'b0; end
      4'd1:    b.data = x0w[15:8];
      4'd2:    b.data = x0w[7:0];
      4'd3:    b.data = x1w[15:8];
      4'd4:    b.data = x1w[7:0];
      4'd5:    begin b.data = paset; b.user = 1'b0; end
      4'd6:    b.data = y0w[15:8];
      4'd7:    b.data = y0w[7:0];
      4'd8:    b.data = y1w[15:8];
      4'd9:    b.data = y1w[7:0];
      default: begin b.data = ramwr; b.user = 1'b0; end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/display_byte_out_reg.sv
// Single-entry AXI-Stream register slice for the byte output, carrying tuser
// (DC bit) and tlast; contents stay frozen while valid is held without ready.
module display_byte_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_user_i,
  input  logic       in_last_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_user_o,
  output logic       out_last_o
);

  logic       valid_q;
  logic [7:0] data_q;
  logic       user_q;
  logic       last_q;

  // The slot can take a new byte when empty or when its byte leaves this cycle.
  assign in_ready_o = !valid_q || out_ready_i;

  // Load a new byte only when the slot frees up; otherwise hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      user_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        data_q <= in_data_i;
        user_q <= in_user_i;
        last_q <= in_last_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_user_o  = user_q;
  assign out_last_o  = last_q;

endmodule

// File: rtl/display_window_scheduler.sv
// Partial-window update sequencer for an 8080 ILI9486 path: emits the
// CASET/PASET/RAMWR preamble, then splits RGB565 pixels into hi/lo bytes.
module display_window_scheduler
  import display_window_scheduler_pkg::*;
#(
  parameter int         DISPLAY_WIDTH  = 480,
  parameter int         DISPLAY_HEIGHT = 320,
  parameter logic [7:0] CMD_CASET      = ILI_CASET,
  parameter logic [7:0] CMD_PASET      = ILI_PASET,
  parameter logic [7:0] CMD_RAMWR      = ILI_RAMWR
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic                      s_win_valid,
  output logic                      s_win_ready,
  input  logic [WIN_DATA_WIDTH-1:0] s_win_data,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic [15:0]               s_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err
);

  localparam coord_ext_t X_LIMIT = coord_ext_t'(DISPLAY_WIDTH);
  localparam coord_ext_t Y_LIMIT = coord_ext_t'(DISPLAY_HEIGHT);

  state_e     state_q, state_d;
  win_t       win_q, win_d;
  logic [3:0] cmd_idx_q, cmd_idx_d;
  pix_cnt_t   pix_cnt_q, pix_cnt_d;
  logic [7:0] lo_byte_q, lo_byte_d;
  logic       tlast_seen_q, tlast_seen_d;
  logic [1:0] err_q, err_d;
  logic       ready_en_q;

  logic       slot_free;
  logic       ob_valid;
  logic [7:0] ob_data;
  logic       ob_user;
  logic       ob_last;
  logic       win_ok;
  logic       pix_final;
  coord_t     span_x;
  coord_t     span_y;
  out_byte_t  cmd_out;

  assign win_ok = (win_q.x1 >= win_q.x0) && (win_q.y1 >= win_q.y0) &&
                  (coord_ext_t'(win_q.x1) < X_LIMIT) && (coord_ext_t'(win_q.y1) < Y_LIMIT);
  assign span_x = win_q.x1 - win_q.x0 + coord_t'(1);
  assign span_y = win_q.y1 - win_q.y0 + coord_t'(1);

  // The current pixel closes the update on count exhaustion or an early source tlast.
  assign pix_final = (pix_cnt_q == pix_cnt_t'(1)) || tlast_seen_q;

  assign busy        = (state_q != ST_IDLE);
  assign s_win_ready = ready_en_q && (state_q == ST_IDLE);
  assign done        = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign err         = err_q;

  // State register.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; DRAIN holds busy until the tlast byte actually leaves.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (s_win_valid && s_win_ready) state_d = ST_CHECK;
      ST_CHECK:  state_d = win_ok ? ST_CMD : ST_IDLE;
      ST_CMD:    if (slot_free && (cmd_idx_q == CMD_LAST_IDX)) state_d = ST_PIX_HI;
      ST_PIX_HI: if (s_axis_tvalid && slot_free) state_d = ST_PIX_LO;
      ST_PIX_LO: if (slot_free) state_d = pix_final ? ST_DRAIN : ST_PIX_HI;
      ST_DRAIN:  if (done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: byte offered to the slice and pixel-side ready.
  always_comb begin
    ob_valid      = 1'b0;
    ob_data       = 8'h00;
    ob_user       = 1'b0;
    ob_last       = 1'b0;
    s_axis_tready = 1'b0;
    cmd_out       = cmd_byte(cmd_idx_q, win_q, CMD_CASET, CMD_PASET, CMD_RAMWR);
    unique case (state_q)
      ST_CMD: begin
        ob_valid = 1'b1;
        ob_data  = cmd_out.data;
        ob_user  = cmd_out.user;
      end
      ST_PIX_HI: begin
        s_axis_tready = slot_free;
        ob_valid      = s_axis_tvalid;
        ob_data       = s_axis_tdata[15:8];
        ob_user       = 1'b1;
      end
      ST_PIX_LO: begin
        ob_valid = 1'b1;
        ob_data  = lo_byte_q;
        ob_user  = 1'b1;
        ob_last  = pix_final;
      end
      default: ;
    endcase
  end

  // Datapath next-state: window capture, validation, byte index and pixel count.
  always_comb begin
    win_d        = win_q;
    cmd_idx_d    = cmd_idx_q;
    pix_cnt_d    = pix_cnt_q;
    lo_byte_d    = lo_byte_q;
    tlast_seen_d = tlast_seen_q;
    err_d        = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (s_win_valid && s_win_ready) begin
          win_d     = s_win_data;
          cmd_idx_d = 4'd0;
        end
      end
      ST_CHECK: begin
        if (win_ok) begin
          err_d        = 2'b00;
          pix_cnt_d    = pix_cnt_t'(span_x) * pix_cnt_t'(span_y);
          tlast_seen_d = 1'b0;
        end else begin
          err_d[0] = 1'b1;
        end
      end
      ST_CMD: if (slot_free) cmd_idx_d = cmd_idx_q + 4'd1;
      ST_PIX_HI: begin
        if (s_axis_tvalid && slot_free) begin
          lo_byte_d    = s_axis_tdata[7:0];
          tlast_seen_d = s_axis_tlast;
        end
      end
      ST_PIX_LO: begin
        if (slot_free) begin
          pix_cnt_d = pix_cnt_q - pix_cnt_t'(1);
          // Source framing and window size must end on the same pixel.
          if ((pix_cnt_q == pix_cnt_t'(1)) != tlast_seen_q) err_d[1] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; ready_en_q keeps s_win_ready low until one edge after reset release.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      win_q        <= '0;
      cmd_idx_q    <= 4'd0;
      pix_cnt_q    <= '0;
      lo_byte_q    <= 8'h00;
      tlast_seen_q <= 1'b0;
      err_q        <= 2'b00;
      ready_en_q   <= 1'b0;
    end else begin
      win_q        <= win_d;
      cmd_idx_q    <= cmd_idx_d;
      pix_cnt_q    <= pix_cnt_d;
      lo_byte_q    <= lo_byte_d;
      tlast_seen_q <= tlast_seen_d;
      err_q        <= err_d;
      ready_en_q   <= 1'b1;
    end
  end

  display_byte_out_reg u_out_reg (
    .clk         (aclk),
    .rst_n       (resetn),
    .in_valid_i  (ob_valid),
    .in_ready_o  (slot_free),
    .in_data_i   (ob_data),
    .in_user_i   (ob_user),
    .in_last_i   (ob_last),
    .out_valid_o (m_axis_tvalid),
    .out_ready_i (m_axis_tready),
    .out_data_o  (m_axis_tdata),
    .out_user_o  (m_axis_tuser),
    .out_last_o  (m_axis_tlast)
  );

endmodule

// File: tb/tb_display_window_scheduler.sv
// Scoreboard bench: stimulus tasks queue expected {data,dc,last} bytes, an
// independent monitor pops and compares on every m_axis handshake.
module tb_display_window_scheduler;

  logic        aclk;
  logic        resetn;
  logic        s_win_valid;
  logic        s_win_ready;
  logic [35:0] s_win_data;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [15:0] s_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  display_window_scheduler dut (
    .aclk          (aclk),
    .resetn        (resetn),
    .s_win_valid   (s_win_valid),
    .s_win_ready   (s_win_ready),
    .s_win_data    (s_win_data),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  logic [9:0] exp_q[$];
  int         checks;
  int         errors;
  int         beat_cnt;
  int         done_cnt;
  bit         stall_mode;
  logic [7:0] main_bytes [19];
  logic [0:18] main_user;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic u, input logic l);
    exp_q.push_back({d, u, l});
  endtask

  task automatic push_cmd(input int x0, input int y0, input int x1, input int y1);
    push(8'h2A, 1'b0, 1'b0);
    push(8'(x0 >> 8), 1'b1, 1'b0);
    push(8'(x0), 1'b1, 1'b0);
    push(8'(x1 >> 8), 1'b1, 1'b0);
    push(8'(x1), 1'b1, 1'b0);
    push(8'h2B, 1'b0, 1'b0);
    push(8'(y0 >> 8), 1'b1, 1'b0);
    push(8'(y0), 1'b1, 1'b0);
    push(8'(y1 >> 8), 1'b1, 1'b0);
    push(8'(y1), 1'b1, 1'b0);
    push(8'h2C, 1'b0, 1'b0);
  endtask

  task automatic push_pix(input logic [15:0] p, input logic last);
    push(p[15:8], 1'b1, 1'b0);
    push(p[7:0], 1'b1, last);
  endtask

  // m_axis_tready: held high, or 50% random when stalling.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [9:0] e;
    logic [9:0] prev;
    bit         prev_hold;
    prev_hold = 1'b0;
    prev      = '0;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        prev_hold = 1'b0;
        continue;
      end
      if (prev_hold)
        chk("hold_stable", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}),
            32'({1'b1, prev}));
      if (m_axis_tvalid && m_axis_tready) begin
        beat_cnt++;
        $display("beat %0d: data=%02h dc=%0d last=%0d", beat_cnt, m_axis_tdata, m_axis_tuser,
                 m_axis_tlast);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data=%02h dc=%0d last=%0d expected no beat",
                   m_axis_tdata, m_axis_tuser, m_axis_tlast);
        end else begin
          e = exp_q.pop_front();
          chk("beat", 32'({m_axis_tdata, m_axis_tuser, m_axis_tlast}), 32'(e));
          if (e[0]) chk("done_on_last", 32'(done), 32'd1);
        end
      end
      if (done) done_cnt++;
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev      = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    end
  end

  task automatic win_req(input int x0, input int y0, input int x1, input int y1);
    bit ok;
    ok = 1'b0;
    @(posedge aclk);
    #1;
    s_win_valid = 1'b1;
    s_win_data  = {9'(x0), 9'(y0), 9'(x1), 9'(y1)};
    for (int t = 0; t < 50; t++) begin
      @(negedge aclk);
      if (s_win_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("win_handshake", 32'(ok), 32'd1);
    @(posedge aclk);
    #1;
    s_win_valid = 1'b0;
    $display("window (%0d,%0d,%0d,%0d) issued", x0, y0, x1, y1);
  endtask

  task automatic send_pix(input logic [15:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    @(posedge aclk);
    #1;
    if (stall_mode) repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    for (int t = 0; t < 200; t++) begin
      @(negedge aclk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pix_accept", 32'(ok), 32'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_complete"}, 32'(ok), 32'd1);
  endtask

  task automatic bad_win(input string tag, input int x0, input int y0, input int x1, input int y1);
    int b0;
    int d0;
    b0 = beat_cnt;
    d0 = done_cnt;
    win_req(x0, y0, x1, y1);
    @(negedge aclk);
    chk({tag, "_ready_low"}, 32'(s_win_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge aclk);
    chk({tag, "_ready_back"}, 32'(s_win_ready), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd1);
    repeat (3) @(negedge aclk);
    chk({tag, "_no_beats"}, 32'(beat_cnt - b0), 32'd0);
    chk({tag, "_no_done"}, 32'(done_cnt - d0), 32'd0);
  endtask

  task automatic run_main(input string tag);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 19; i++) push(main_bytes[i], main_user[i], i == 18);
    win_req(10, 20, 11, 21);
    @(negedge aclk);
    chk({tag, "_lat_c0"}, 32'(m_axis_tvalid), 32'd0);
    @(negedge aclk);
    chk({tag, "_lat_c1"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_err_cleared"}, 32'(err), 32'd0);
    @(negedge aclk);
    chk({tag, "_first_byte"}, 32'(m_axis_tvalid), 32'd1);
    send_pix(16'hF800, 1'b0);
    send_pix(16'h07E0, 1'b0);
    send_pix(16'h001F, 1'b0);
    send_pix(16'hFFFF, 1'b1);
    wait_done(tag);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] px;
    int          d0;
    checks        = 0;
    errors        = 0;
    beat_cnt      = 0;
    done_cnt      = 0;
    stall_mode    = 1'b0;
    main_bytes    = '{8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0B, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h15,
                      8'h2C, 8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    main_user     = 19'b0111101111011111111;
    resetn        = 1'b1;
    s_win_valid   = 1'b0;
    s_win_data    = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 16'h0000;
    #1 resetn = 1'b0;

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, busy,
                              done, err, s_win_ready, s_axis_tready}), 32'd0);
    @(negedge aclk);
    resetn = 1'b1;
    #1;
    chk("ready_after_release", 32'(s_win_ready), 32'd0);
    @(negedge aclk);
    chk("ready_one_cycle_later", 32'(s_win_ready), 32'd1);
    chk("idle_not_busy", 32'(busy), 32'd0);

    // Rejected windows.
    bad_win("bad_x_order", 5, 0, 4, 0);
    bad_win("bad_x_range", 0, 0, 480, 0);
    bad_win("bad_y_range", 0, 0, 0, 320);

    // Reference 2x2 window.
    run_main("main");

    // Source tlast on pixel 2 of a 4-pixel window.
    d0 = done_cnt;
    push_cmd(0, 0, 1, 1);
    push_pix(16'h1234, 1'b0);
    push_pix(16'hABCD, 1'b1);
    win_req(0, 0, 1, 1);
    send_pix(16'h1234, 1'b0);
    send_pix(16'hABCD, 1'b1);
    wait_done("early");
    chk("early_err", 32'(err), 32'd2);
    chk("early_done", 32'(done_cnt - d0), 32'd1);

    // Count runs out before source tlast; following pixel must be held.
    d0 = done_cnt;
    push_cmd(0, 0, 1, 0);
    push_pix(16'h1111, 1'b0);
    push_pix(16'h2222, 1'b1);
    win_req(0, 0, 1, 0);
    @(negedge aclk);
    @(negedge aclk);
    chk("late_err_cleared", 32'(err), 32'd0);
    send_pix(16'h1111, 1'b0);
    send_pix(16'h2222, 1'b0);
    wait_done("late");
    chk("late_err", 32'(err), 32'd2);
    chk("late_done", 32'(done_cnt - d0), 32'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h3333;
    s_axis_tlast  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      chk("held_tready", 32'(s_axis_tready), 32'd0);
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    // 1x1 window at the bottom-right corner.
    d0 = done_cnt;
    push_cmd(479, 319, 479, 319);
    push_pix(16'hC3A5, 1'b1);
    win_req(479, 319, 479, 319);
    send_pix(16'hC3A5, 1'b1);
    wait_done("corner");
    chk("corner_err", 32'(err), 32'd0);
    chk("corner_done", 32'(done_cnt - d0), 32'd1);

    // Random stalls on both sides, 4x2 window.
    stall_mode = 1'b1;
    d0 = done_cnt;
    push_cmd(100, 200, 103, 201);
    for (int i = 0; i < 8; i++) begin
      px = 16'(16'h1357 * (i + 1));
      push_pix(px, i == 7);
    end
    win_req(100, 200, 103, 201);
    for (int i = 0; i < 8; i++) begin
      px = 16'(16'h1357 * (i + 1));
      send_pix(px, i == 7);
    end
    wait_done("stall");
    chk("stall_err", 32'(err), 32'd0);
    chk("stall_done", 32'(done_cnt - d0), 32'd1);
    stall_mode = 1'b0;
    @(posedge aclk);

    // Full-screen update interrupted by reset mid-stream.
    push_cmd(0, 0, 479, 319);
    win_req(0, 0, 479, 319);
    for (int i = 0; i < 3; i++) begin
      px = 16'(16'h0F0F + i);
      push_pix(px, 1'b0);
      send_pix(px, 1'b0);
    end
    for (int t = 0; t < 500; t++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
    end
    chk("fullscreen_bytes_out", 32'(exp_q.size()), 32'd0);
    chk("fullscreen_busy", 32'(busy), 32'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 16'h5555;
    #2 resetn = 1'b0;
    #1;
    chk("midreset_outputs", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, busy,
                                 done, err, s_win_ready, s_axis_tready}), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    @(negedge aclk);
    resetn = 1'b1;
    @(negedge aclk);
    chk("midreset_ready", 32'(s_win_ready), 32'd1);
    run_main("restart");

    repeat (5) @(negedge aclk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
